// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: bus ID width, register word and the broadcast record
// seen by reservation stations and the register file.
package cdb_arbiter_pkg;

  localparam int CDB_ID_WIDTH = 3;

  typedef logic [31:0] register;

  typedef struct packed {
    logic                    valid;
    logic [CDB_ID_WIDTH-1:0] rs_id;
    register                 result;
  } cdb_bus;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Reservation-station side of the CDB arbiter: requests and results in,
// retire strobes, CDB broadcast and statistics out.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RS     = 8
);

  logic [NUM_RS-1:0]                 ready;
  logic [NUM_RS-1:0]                 has_rd;
  logic [NUM_RS-1:0][DATA_WIDTH-1:0] result;
  logic [NUM_RS-1:0]                 cancel;
  logic [NUM_RS-1:0]                 do_retire;
  logic                              cdb_valid;
  logic [DATA_WIDTH-1:0]             cdb_result;
  logic [CDB_ID_WIDTH-1:0]           cdb_rs_id;
  logic [31:0]                       retire_count;
  logic [31:0]                       conflict_count;

  modport master (
    output ready, has_rd, result, cancel,
    input  do_retire, cdb_valid, cdb_result, cdb_rs_id,
    input  retire_count, conflict_count
  );

  modport slave (
    input  ready, has_rd, result, cancel,
    output do_retire, cdb_valid, cdb_result, cdb_rs_id,
    output retire_count, conflict_count
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first set request at or after ptr,
// wrapping modulo NUM_RS.
module cdb_arbiter_rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_RS = 8
) (
  input  logic [NUM_RS-1:0]       req,
  input  logic [CDB_ID_WIDTH-1:0] ptr,
  output logic [CDB_ID_WIDTH-1:0] winner,
  output logic                    found
);

  int idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_RS; k++) begin
      idx = (int'(ptr) + k) % NUM_RS;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = CDB_ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one retiring reservation station per cycle,
// granted and broadcast combinationally; pointer and statistics registered.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RS     = 8
) (
  input logic            clk,
  input logic            rst,
  cdb_arbiter_if.slave   bus
);

  logic [NUM_RS-1:0]       elig;
  logic [CDB_ID_WIDTH-1:0] win;
  logic                    found;
  logic                    grant;
  logic                    multi;
  logic [CDB_ID_WIDTH-1:0] ptr;
  logic [CDB_ID_WIDTH-1:0] ptr_nxt;
  logic [31:0]             retire_cnt;
  logic [31:0]             conflict_cnt;

  // A squashed result must never reach the bus, so cancel masks the request.
  assign elig  = bus.ready & ~bus.cancel;
  assign multi = |(elig & (elig - NUM_RS'(1)));
  assign grant = found && !rst;

  assign ptr_nxt = (win == CDB_ID_WIDTH'(NUM_RS - 1)) ? '0 : win + CDB_ID_WIDTH'(1);

  cdb_arbiter_rr_pick #(
    .NUM_RS (NUM_RS)
  ) u_pick (
    .req    (elig),
    .ptr    (ptr),
    .winner (win),
    .found  (found)
  );

  // Zero-latency grant: stations retire on the same edge they see the strobe.
  always_comb begin
    bus.do_retire  = '0;
    bus.cdb_valid  = 1'b0;
    bus.cdb_result = '0;
    bus.cdb_rs_id  = '0;
    if (grant) begin
      bus.do_retire  = NUM_RS'(1) << win;
      bus.cdb_valid  = bus.has_rd[win];
      bus.cdb_result = bus.result[win];
      bus.cdb_rs_id  = win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      retire_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (found) begin
        ptr        <= ptr_nxt;
        retire_cnt <= retire_cnt + 32'd1;
      end
      if (multi) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
    end
  end

  assign bus.retire_count   = retire_cnt;
  assign bus.conflict_count = conflict_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(bus.do_retire));
      assert ((bus.do_retire & ~elig) == '0);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a vector table walked through the round-robin
// pointer, plus hand-written reset/idle and reset-during-request sequences.
module tb_cdb_arbiter;

  logic clk;
  logic rst;

  cdb_arbiter_if #(.DATA_WIDTH(32), .NUM_RS(8)) bus ();

  cdb_arbiter #(.DATA_WIDTH(32), .NUM_RS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [7:0]  ready;
    logic [7:0]  cancel;
    logic [7:0]  has_rd;
    logic [31:0] r2;
    logic [7:0]  e_dr;
    logic        e_valid;
    logic [2:0]  e_id;
    logic [31:0] e_res;
    logic [31:0] e_rc;
    logic [31:0] e_cc;
  } vec_t;

  vec_t tv[13];

  function automatic logic [31:0] pat(int i);
    return (32'(i + 1) << 28) | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] rdy, input logic [7:0] cnl,
                       input logic [7:0] hrd, input logic [31:0] r2);
    bus.ready  = rdy;
    bus.cancel = cnl;
    bus.has_rd = hrd;
    for (int i = 0; i < 8; i++) bus.result[i] = pat(i);
    bus.result[2] = r2;
  endtask

  task automatic chk_bus(input string tag, input logic [7:0] dr, input logic v,
                         input logic [2:0] id, input logic [31:0] res);
    chk({tag, ".do_retire"},  32'(bus.do_retire),  32'(dr));
    chk({tag, ".cdb_valid"},  32'(bus.cdb_valid),  32'(v));
    chk({tag, ".cdb_rs_id"},  32'(bus.cdb_rs_id),  32'(id));
    chk({tag, ".cdb_result"}, bus.cdb_result,      res);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] rc, input logic [31:0] cc);
    chk({tag, ".retire_count"},   bus.retire_count,   rc);
    chk({tag, ".conflict_count"}, bus.conflict_count, cc);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //            ready   cancel  has_rd  r2            dr     v     id    res           rc  cc
    tv[0]  = '{8'h04, 8'h00, 8'h04, 32'hDEADBEEF, 8'h04, 1'b1, 3'd2, 32'hDEADBEEF, 1,  0};
    tv[1]  = '{8'h0C, 8'h00, 8'h08, 32'h30000002, 8'h08, 1'b1, 3'd3, 32'h40000003, 2,  1};
    tv[2]  = '{8'h00, 8'h00, 8'hFF, 32'h30000002, 8'h00, 1'b0, 3'd0, 32'h00000000, 2,  1};
    tv[3]  = '{8'h11, 8'h00, 8'hFF, 32'h30000002, 8'h10, 1'b1, 3'd4, 32'h50000004, 3,  2};
    tv[4]  = '{8'h80, 8'h00, 8'h00, 32'h30000002, 8'h80, 1'b0, 3'd7, 32'h80000007, 4,  2};
    tv[5]  = '{8'h83, 8'h00, 8'hFF, 32'h30000002, 8'h01, 1'b1, 3'd0, 32'h10000000, 5,  3};
    tv[6]  = '{8'h82, 8'h00, 8'hFF, 32'h30000002, 8'h02, 1'b1, 3'd1, 32'h20000001, 6,  4};
    tv[7]  = '{8'h80, 8'h00, 8'hFF, 32'h30000002, 8'h80, 1'b1, 3'd7, 32'h80000007, 7,  4};
    tv[8]  = '{8'h03, 8'h01, 8'hFF, 32'h30000002, 8'h02, 1'b1, 3'd1, 32'h20000001, 8,  4};
    tv[9]  = '{8'h20, 8'h00, 8'hDF, 32'h30000002, 8'h20, 1'b0, 3'd5, 32'h60000005, 9,  4};
    tv[10] = '{8'h40, 8'h40, 8'hFF, 32'h30000002, 8'h00, 1'b0, 3'd0, 32'h00000000, 9,  4};
    tv[11] = '{8'hFF, 8'hFF, 8'hFF, 32'h30000002, 8'h00, 1'b0, 3'd0, 32'h00000000, 9,  4};
    tv[12] = '{8'h60, 8'h40, 8'hFF, 32'h30000002, 8'h20, 1'b1, 3'd5, 32'h60000005, 10, 4};

    rst = 1'b1;
    drive(8'h00, 8'h00, 8'h00, 32'h30000002);
    repeat (2) @(posedge clk);
    #1;
    chk_bus("rst", 8'h00, 1'b0, 3'd0, 32'h0);
    chk_cnt("rst", 32'd0, 32'd0);
    rst = 1'b0;

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_bus($sformatf("idle%0d", c), 8'h00, 1'b0, 3'd0, 32'h0);
      @(posedge clk);
      #1;
      chk_cnt($sformatf("idle%0d", c), 32'd0, 32'd0);
    end

    for (int v = 0; v < 13; v++) begin
      drive(tv[v].ready, tv[v].cancel, tv[v].has_rd, tv[v].r2);
      @(negedge clk);
      chk_bus($sformatf("v%0d", v), tv[v].e_dr, tv[v].e_valid, tv[v].e_id, tv[v].e_res);
      @(posedge clk);
      #1;
      chk_cnt($sformatf("v%0d", v), tv[v].e_rc, tv[v].e_cc);
    end

    // Reset while every station requests and the pointer sits at 6.
    drive(8'hFF, 8'h00, 8'hFF, 32'h30000002);
    rst = 1'b1;
    @(negedge clk);
    chk_bus("rst_req", 8'h00, 1'b0, 3'd0, 32'h0);
    @(posedge clk);
    #1;
    chk_cnt("rst_req", 32'd0, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_bus("post_rst", 8'h01, 1'b1, 3'd0, 32'h10000000);
    @(posedge clk);
    #1;
    chk_cnt("post_rst", 32'd1, 32'd1);
    drive(8'hFE, 8'h00, 8'hFF, 32'h30000002);
    @(negedge clk);
    chk_bus("post_rst2", 8'h02, 1'b1, 3'd1, 32'h20000001);
    @(posedge clk);
    #1;
    chk_cnt("post_rst2", 32'd2, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
